imem_loader: RTL and testbench

- Writer side of the core's instruction-memory write port (write_en / write_addr / write_data).
- Takes a byte stream (valid/ready) from a host link and assembles little-endian 32-bit words.
- Writes the words to consecutive IMEM word addresses, starting at 0.
- Holds the core in reset while loading, then releases it so rv32i_core boots from the freshly loaded image without bench-side pokes.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_word_packer.sv | 32 +++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Frame: 16-bit little-endian word count, then 4 bytes per word, LSB first.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    HOLD,
    DONE,
    ERR
  } state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // A frame may fill the whole memory but never exceed it.
  function automatic logic len_oversize(input logic [15:0] len, input int addr_w);
    return {16'd0, len} > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Collects host bytes into little-endian 32-bit words; word_valid marks the
// cycle in which the final byte of a word is being transferred.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_idx;
  logic [23:0] low_bytes;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx  <= '0;
      low_bytes <= '0;
    end else if (shift_en) begin
      byte_idx  <= byte_idx + 2'd1;
      low_bytes <= {byte_data, low_bytes[23:8]};
    end
  end

  // The top lane is taken straight from the bus so the word is ready on the 4th transfer.
  assign word       = {byte_data, low_bytes};
  assign word_valid = shift_en && (byte_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into IMEM and holds the core in reset
// until the image is complete.
//
//   state | meaning
//   IDLE  | waiting for start, core held in reset
//   LEN0  | expecting low length byte
//   LEN1  | expecting high length byte, length checked here
//   DATA  | collecting bytes of the current word
//   WRITE | one-cycle IMEM write of the assembled word
//   HOLD  | keeping core_rst high for RST_HOLD cycles
//   DONE  | image loaded, core released
//   ERR   | length too large, waits for a new start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [15:0] word_cnt;
  logic [15:0] hold_cnt;
  logic        xfer;
  logic        pack_clear;
  logic        pack_shift;
  logic [31:0] pack_word;
  logic        pack_valid;

  assign xfer       = byte_valid & byte_ready;
  assign len_in     = {byte_data, len_lo};
  assign pack_shift = xfer && (state == DATA);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .shift_en   (pack_shift),
    .byte_data  (byte_data),
    .word       (pack_word),
    .word_valid (pack_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    pack_clear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = LEN0;
          pack_clear = 1'b1;
        end
      end
      LEN0: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) state_nxt = LEN1;
      end
      LEN1: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) begin
          if (len_oversize(len_in, ADDR_W)) state_nxt = ERR;
          else if (len_in == 16'd0)         state_nxt = HOLD;
          else                              state_nxt = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (pack_valid) state_nxt = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        if (word_cnt + 16'd1 == len) state_nxt = HOLD;
        else                         state_nxt = DATA;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_cnt == 16'd0) state_nxt = DONE;
      end
      DONE, ERR: begin
        if (start) begin
          state_nxt  = LEN0;
          pack_clear = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      hold_cnt   <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= 1'b0;
      if (pack_clear) word_cnt <= '0;
      if (xfer && state == LEN0) len_lo <= byte_data;
      if (xfer && state == LEN1) len    <= len_in;
      // Registering the write here gives the one-cycle latency after the 4th byte.
      if (pack_valid) begin
        write_en   <= 1'b1;
        write_addr <= word_cnt[ADDR_W-1:0];
        write_data <= pack_word;
      end
      if (state == WRITE) word_cnt <= word_cnt + 16'd1;
      if (state != HOLD && state_nxt == HOLD)  hold_cnt <= 16'(RST_HOLD - 1);
      else if (state == HOLD && hold_cnt != 0) hold_cnt <= hold_cnt - 16'd1;
    end
  end

  assign core_rst = (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: frames are built from word
// lists, the expected IMEM writes are queued, and a monitor checks each write.
module tb_imem_loader;

  localparam int ADDR_W   = 10;
  localparam int RST_HOLD = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [31:0]       write_data;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         exp_e;
  logic [31:0] frame_words[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_event = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic finish_now();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Scoreboard monitor: every IMEM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && write_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", write_addr, write_data);
      end else begin
        exp_e = exp_q.pop_front();
        check("write_addr", 32'(write_addr), 32'(exp_e.addr));
        check("write_data", write_data, exp_e.data);
      end
      check("ready_during_write", 32'(byte_ready), 32'd0);
      last_event = cyc;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_core_rst", 32'(core_rst), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp);
    int tries;
    bit acc;
    tries = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      byte_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      byte_data  = byte_valid ? b : 8'($urandom());
      if (byte_valid && byte_ready) begin
        acc = 1'b1;
        last_event = cyc;
      end
      tries++;
      if (!acc && tries > 200) begin
        errors++;
        checks++;
        $display("FAIL byte_timeout: byte %0h not accepted after %0d cycles, expected acceptance", b, tries);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "byte handshake stalled");
      end
    end
  endtask

  task automatic fill_words(input int n, input bit addr_data);
    frame_words.delete();
    for (int i = 0; i < n; i++) frame_words.push_back(addr_data ? 32'(i) : $urandom());
  endtask

  // Reference: a legal frame writes word i to address i; an oversize frame writes nothing.
  task automatic run_frame(input int n, input bit bp, input int max_words);
    logic [15:0] len16;
    logic [7:0]  bytes[$];
    int          nw;
    len16 = 16'(n);
    bytes.push_back(len16[7:0]);
    bytes.push_back(len16[15:8]);
    nw = (n > DEPTH) ? 0 : ((n < max_words) ? n : max_words);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: frame_words[i]});
      for (int k = 0; k < 4; k++) bytes.push_back(frame_words[i][8*k +: 8]);
    end
    pulse_start();
    foreach (bytes[i]) send_byte(bytes[i], bp);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_hold_cycles"}, 32'(cyc - last_event), 32'(RST_HOLD + 1));
    check({name, "_core_rst"}, 32'(core_rst), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_write_en"}, 32'(write_en), 32'd0);
    check({name, "_write_addr"}, 32'(write_addr), 32'd0);
    check({name, "_write_data"}, write_data, 32'd0);
    check({name, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({name, "_core_rst"}, 32'(core_rst), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed two-word frame, valid held high.
    frame_words.delete();
    frame_words.push_back(32'hDEADBEEF);
    frame_words.push_back(32'h12345678);
    run_frame(2, 1'b0, 1 << 16);
    wait_done("two_word");

    // Same frame with back-pressure on the host side.
    run_frame(2, 1'b1, 1 << 16);
    wait_done("two_word_bp");

    // Random frames with random gaps.
    for (int t = 0; t < 3; t++) begin
      fill_words($urandom_range(1, 12), 1'b0);
      run_frame(frame_words.size(), 1'b1, 1 << 16);
      wait_done("random_bp");
    end

    // Zero length: straight to HOLD then DONE.
    run_frame(0, 1'b0, 1 << 16);
    wait_done("zero_len");

    // Oversize frame enters ERR and ignores offered bytes.
    frame_words.delete();
    run_frame(DEPTH + 1, 1'b0, 1 << 16);
    check("oversize_error", 32'(error), 32'd1);
    check("oversize_core_rst", 32'(core_rst), 32'd1);
    check("oversize_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("oversize_still_error", 32'(error), 32'd1);
    check("oversize_ready_held", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    fill_words(3, 1'b0);
    run_frame(3, 1'b1, 1 << 16);
    wait_done("after_error");

    // Full memory depth, data equals address.
    fill_words(DEPTH, 1'b1);
    run_frame(DEPTH, 1'b0, 1 << 16);
    wait_done("full_depth");

    // Reset after two of four words; then a fresh load from address 0.
    fill_words(4, 1'b0);
    run_frame(4, 1'b1, 2);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midload_writes_seen", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    rst = 1'b0;
    fill_words(2, 1'b0);
    run_frame(2, 1'b1, 1 << 16);
    wait_done("after_reset");

    repeat (3) @(negedge clk);
    finish_now();
  end

endmodule
